// File: rtl/divide_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
interface divide_if #(
  parameter int n = 16
);
  logic         s;
  logic [n-1:0] dataa;
  logic [n-1:0] datab;
  logic [n-1:0] q;
  logic [n-1:0] r;
  logic         done;
  logic         div0;

  modport master (output s, dataa, datab, input q, r, done, div0);
  modport slave  (input s, dataa, datab, output q, r, done, div0);
endinterface

// File: rtl/divide.sv
// Sequential restoring divider: unsigned n-bit dividend / divisor, one quotient bit per clock.
// state | meaning
// S1    | idle, waiting for s to load operands
// S2    | compute, one restoring iteration per edge
// S3    | done, results valid until s drops
module divide #(
  parameter int n = 16
) (
  input  logic     clk,
  input  logic     rstn,
  divide_if.slave  bus
);
  localparam int CW = (n > 1) ? $clog2(n) : 1;

  localparam logic [1:0] S1 = 2'd0;
  localparam logic [1:0] S2 = 2'd1;
  localparam logic [1:0] S3 = 2'd2;

  logic [1:0]    r_state;
  logic [n-1:0]  r_a;
  logic [n-1:0]  r_b;
  logic [n:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_q;
  logic [n-1:0]  r_r;
  logic          r_div0;

  logic [n:0]    w_t;
  logic          w_ge;
  logic [n:0]    w_rem_nxt;
  logic [n-1:0]  w_a_nxt;
  logic          w_last;
  logic          w_unused;

  // Shift {R,A} left by one and trial-subtract the divisor.
  assign w_t       = {r_rem[n-1:0], r_a[n-1]};
  assign w_ge      = (w_t >= {1'b0, r_b});
  assign w_rem_nxt = w_ge ? (w_t - {1'b0, r_b}) : w_t;
  assign w_a_nxt   = {r_a[n-2:0], w_ge};
  assign w_last    = (r_cnt == CW'(n - 1));
  // Restored remainder is always below the divisor, so the top bit never feeds back.
  assign w_unused  = r_rem[n];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S1;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_r     <= '0;
      r_div0  <= 1'b0;
    end else begin
      case (r_state)
        S1: begin
          if (bus.s) begin
            r_a     <= bus.dataa;
            r_b     <= bus.datab;
            r_rem   <= '0;
            r_cnt   <= '0;
            r_state <= S2;
          end
        end
        S2: begin
          r_a   <= w_a_nxt;
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_q     <= w_a_nxt;
            r_r     <= w_rem_nxt[n-1:0];
            r_div0  <= (r_b == '0);
            r_state <= S3;
          end
        end
        S3: begin
          if (!bus.s) r_state <= S1;
        end
        default: r_state <= S1;
      endcase
    end
  end

  assign bus.q    = r_q;
  assign bus.r    = r_r;
  assign bus.div0 = r_div0;
  assign bus.done = (r_state == S3);
endmodule

// File: tb/tb_divide.sv
// Scoreboard bench for the restoring divider at n=16 and n=8.
module tb_divide;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  divide_if #(.n(16)) bus16();
  divide_if #(.n(8))  bus8();

  divide #(.n(16)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));
  divide #(.n(8))  dut8  (.clk(clk), .rstn(rstn), .bus(bus8));

  typedef struct packed { logic [15:0] q; logic [15:0] r; logic div0; } res16_t;
  typedef struct packed { logic [7:0] q; logic [7:0] r; logic div0; } res8_t;

  res16_t exp16[$];
  res8_t  exp8[$];
  res16_t m16;
  res8_t  m8;
  logic   done16_d = 1'b0;
  logic   done8_d  = 1'b0;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_q = '0;
  logic [15:0] prev_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result on each rising edge of done.
  always @(negedge clk) begin
    if (bus16.done && !done16_d) begin
      if (exp16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon16_unexpected_done actual=1 expected=0");
      end else begin
        m16 = exp16.pop_front();
        chk("mon16_q", 32'(bus16.q), 32'(m16.q));
        chk("mon16_r", 32'(bus16.r), 32'(m16.r));
        chk("mon16_div0", 32'(bus16.div0), 32'(m16.div0));
      end
    end
    done16_d <= bus16.done;
  end

  always @(negedge clk) begin
    if (bus8.done && !done8_d) begin
      if (exp8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon8_unexpected_done actual=1 expected=0");
      end else begin
        m8 = exp8.pop_front();
        chk("mon8_q", 32'(bus8.q), 32'(m8.q));
        chk("mon8_r", 32'(bus8.r), 32'(m8.r));
        chk("mon8_div0", 32'(bus8.div0), 32'(m8.div0));
      end
    end
    done8_d <= bus8.done;
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic [15:0] eq,
                      input logic [15:0] er, input logic ed, input int hold, input bit pulse);
    int edges;
    @(negedge clk);
    bus16.s     = 1'b1;
    bus16.dataa = a;
    bus16.datab = b;
    exp16.push_back('{q: eq, r: er, div0: ed});
    @(posedge clk); #1;
    // operands must only be sampled at the load edge
    bus16.dataa = ~a;
    bus16.datab = b + 16'd1;
    if (pulse) bus16.s = 1'b0;
    edges = 0;
    while (!bus16.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 8) begin
        chk("hold_prev_q", 32'(bus16.q), 32'(prev_q));
        chk("hold_prev_r", 32'(bus16.r), 32'(prev_r));
      end
    end
    chk("latency16", 32'(edges), 32'd16);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(bus16.done), 32'd1);
      chk("hold_q", 32'(bus16.q), 32'(eq));
      chk("hold_r", 32'(bus16.r), 32'(er));
    end
    if (!pulse) begin
      @(negedge clk);
      bus16.s = 1'b0;
    end
    @(posedge clk); #1;
    chk("done_drop16", 32'(bus16.done), 32'd0);
    prev_q = eq;
    prev_r = er;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                     input logic [7:0] er, input logic ed);
    int edges;
    @(negedge clk);
    bus8.s     = 1'b1;
    bus8.dataa = a;
    bus8.datab = b;
    exp8.push_back('{q: eq, r: er, div0: ed});
    @(posedge clk); #1;
    bus8.dataa = ~a;
    edges = 0;
    while (!bus8.done && edges < 30) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency8", 32'(edges), 32'd8);
    @(negedge clk);
    bus8.s = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    rstn = 1'b0;
    bus16.s = 1'b0; bus16.dataa = '0; bus16.datab = '0;
    bus8.s  = 1'b0; bus8.dataa  = '0; bus8.datab  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done16", 32'(bus16.done), 32'd0);
    chk("rst_q16", 32'(bus16.q), 32'd0);
    chk("rst_r16", 32'(bus16.r), 32'd0);
    chk("rst_div0_16", 32'(bus16.div0), 32'd0);
    chk("rst_done8", 32'(bus8.done), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    op16(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 5, 1'b0);
    op16(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 0, 1'b0);
    op16(16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 0, 1'b0);
    op16(16'h1234, 16'd0, 16'hFFFF, 16'h1234, 1'b1, 1, 1'b0);
    op16(16'd40, 16'd8, 16'd5, 16'd0, 1'b0, 0, 1'b0);
    op16(16'd200, 16'd9, 16'd22, 16'd2, 1'b0, 0, 1'b1);

    // abort 1000/3 partway through with an asynchronous reset
    @(negedge clk);
    bus16.s = 1'b1; bus16.dataa = 16'd1000; bus16.datab = 16'd3;
    @(posedge clk); #1;
    repeat (8) @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("abort_done", 32'(bus16.done), 32'd0);
    chk("abort_q", 32'(bus16.q), 32'd0);
    chk("abort_r", 32'(bus16.r), 32'd0);
    chk("abort_div0", 32'(bus16.div0), 32'd0);
    bus16.s = 1'b0;
    prev_q = '0;
    prev_r = '0;
    @(negedge clk);
    rstn = 1'b1;
    op16(16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 0, 1'b0);

    op8(8'd255, 8'd16, 8'd15, 8'd15, 1'b0);
    op8(8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
    op8(8'd77, 8'd77, 8'd1, 8'd0, 1'b0);
    op8(8'd0, 8'd5, 8'd0, 8'd0, 1'b0);
    op8(8'd200, 8'd0, 8'hFF, 8'd200, 1'b1);
    op8(8'd129, 8'd128, 8'd1, 8'd1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i % 10 == 0) rb = ra;
      if (rb == 8'd0) op8(ra, rb, 8'hFF, ra, 1'b1);
      else            op8(ra, rb, ra / rb, ra % rb, 1'b0);
    end

    repeat (2) @(posedge clk);
    chk("drain16", 32'(exp16.size()), 32'd0);
    chk("drain8", 32'(exp8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
